wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; state updates on posedge only.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; clears all state.
REQ-003 SHALL have port: in_valid  input  1  MEM-stage instruction present.
REQ-004 SHALL have ports: in_reg_write (1), in_rd (5), in_ecall (1), in_funct3 (3); all inputs; MEM-stage control fields.
REQ-005 SHALL have port: in_wb_sel  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
REQ-006 SHALL have ports: in_alu_result, in_mem_rdata, in_pc_plus4; each input, 32 bits; result sources, alu_result[1:0] being the byte address.
REQ-007 SHALL have port: halt_in  input  1  register-file halt decision, valid while ecall_sig=1.
REQ-008 SHALL have ports: wb_en (1), rd_index (5), wb_data (32), ecall_sig (1); all outputs; register-file write port and ecall strobe.
REQ-009 SHALL have port: stall_req  output  1  upstream holds MEM-stage inputs while high.
REQ-010 SHALL have ports: halted (1), retire_count (32); both outputs; halted status and retired-instruction count.

Function
REQ-011 SHALL register all outputs except stall_req and halted, which decode from state; latency 1 cycle: fields captured at posedge N drive outputs through cycle N+1 (register file writes on the negedge within N+1).
REQ-012 SHALL capture inputs only when in_valid=1 and state=RUN; otherwise the output register loads a bubble (wb_en=0, rd_index=0, wb_data=0, ecall_sig=0).
REQ-013 SHALL drive wb_en = captured valid & in_reg_write & (in_rd != 0); rd_index = in_rd when captured, else 0.
REQ-014 SHALL compute wb_data before capture: sel 00/11 alu_result; 10 pc_plus4; 01 load-aligned mem_rdata per REQ-015.
REQ-015 SHALL align loads by funct3: 000 LB sign-extend byte alu_result[1:0]; 100 LBU zero-extend the same byte; 001 LH sign-extend halfword alu_result[1]; 101 LHU zero-extend the same; 010 LW full word; other codes pass mem_rdata unchanged.
REQ-016 SHALL ignore alu_result[0] for halfwords and alu_result[1:0] for words; no misalignment trap.
REQ-017 SHALL implement FSM states RUN, ECALL, HALTED.
REQ-018 RUN: capture of in_valid=1 with in_ecall=1 -> ECALL, ecall_sig=1 next cycle; stays RUN otherwise.
REQ-019 ECALL: ecall_sig=1 and stall_req=1 for exactly one cycle; sample halt_in at the posedge ending it: 1 -> HALTED, 0 -> RUN.
REQ-020 HALTED: stall_req=1, halted=1, wb_en=0, all inputs ignored; exit only via reset.
REQ-021 SHALL set stall_req=0 in RUN.
REQ-022 SHALL increment retire_count on each valid capture, including ecall; saturate at 0xFFFFFFFF, no wrap.
REQ-023 SHALL treat in_ecall with in_reg_write=1 as ecall; wb_en still follows REQ-013.

Reset
REQ-024 SHALL on reset=0, immediately and regardless of clk, force state=RUN, wb_en=0, rd_index=0, wb_data=0, ecall_sig=0, retire_count=0; stall_req=0, halted=0.
REQ-025 SHALL abort any ECALL/HALTED state on reset mid-operation; first capture after reset release occurs at the first posedge with reset=1.

Verification
REQ-026 ALU writeback: valid, reg_write=1, rd=5, sel=00, alu=0x1234 -> next cycle wb_en=1, rd_index=5, wb_data=0x00001234, retire_count=1.
REQ-027 Loads, mem_rdata=0x80FF7F01: LB addr 3 -> 0xFFFFFF80; LBU addr 2 -> 0x000000FF; LH addr 2 -> 0xFFFF80FF; LHU addr 0 -> 0x00007F01; LW -> 0x80FF7F01.
REQ-028 x0 suppression: reg_write=1, rd=0, sel=10, pc_plus4=0x40 -> wb_en=0, retire_count still increments.
REQ-029 Ecall: ecall captured -> ecall_sig=1, stall_req=1 one cycle; halt_in=0 -> RUN, next in_valid captured; repeat with halt_in=1 -> halted=1, stall_req=1, later valid inputs produce wb_en=0 and no count change.
REQ-030 Reset mid-HALTED and with retire_count=0xFFFFFFFF (further valids keep 0xFFFFFFFF): reset low asynchronously between edges -> all outputs zero same cycle, halted=0, normal capture resumes.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage -- write-back stage of a 5-stage RISC-V pipeline.
//
// Purpose: selects the write-back result (ALU, aligned load data or PC+4),
// registers it toward the register file, and runs the ECALL/HALT handshake.
// An ECALL holds the pipeline for one cycle while the register file decides
// whether to halt. Once HALTED, the stage leaves that state only through reset.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low; clears all state
//   in_valid       MEM-stage instruction present
//   in_reg_write   instruction writes rd
//   in_rd          destination register index
//   in_ecall       instruction is an ECALL
//   in_funct3      load width/sign code
//   in_wb_sel      result select: 00 ALU, 01 load, 10 PC+4, 11 ALU
//   in_alu_result  ALU result; bits [1:0] are the load byte address
//   in_mem_rdata   raw 32-bit word read from data memory
//   in_pc_plus4    link value for JAL/JALR
//   halt_in        register-file halt decision, sampled while ecall_sig=1
//   wb_en          register-file write enable
//   rd_index       register-file write index
//   wb_data        register-file write data
//   ecall_sig      ECALL strobe, high for the single ECALL cycle
//   stall_req      upstream holds the MEM-stage inputs while high
//   halted         the stage is halted
//   retire_count   saturating count of retired instructions
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  input  logic        in_ecall,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_mem_rdata,
  input  logic [31:0] in_pc_plus4,
  input  logic        halt_in,
  output logic        wb_en,
  output logic [4:0]  rd_index,
  output logic [31:0] wb_data,
  output logic        ecall_sig,
  output logic        stall_req,
  output logic        halted,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ECALL  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic        capture;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] result;

  // An instruction is taken only while running; everything else is a bubble.
  assign capture = in_valid && (state == RUN);

  assign stall_req = (state != RUN);
  assign halted    = (state == HALTED);

  // Halfwords use only address bit 1; words ignore the address completely.
  // Misaligned addresses are silently truncated, never trapped.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    load_byte = in_mem_rdata[7:0];
    load_half = in_alu_result[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    case (in_alu_result[1:0])
      2'd1:    load_byte = in_mem_rdata[15:8];
      2'd2:    load_byte = in_mem_rdata[23:16];
      2'd3:    load_byte = in_mem_rdata[31:24];
      default: load_byte = in_mem_rdata[7:0];
    endcase
  end

  always_comb begin
    load_data = in_mem_rdata;
    case (in_funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'd0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = in_mem_rdata;
    endcase
  end

  always_comb begin
    result = in_alu_result;
    case (in_wb_sel)
      2'b01:   result = load_data;
      2'b10:   result = in_pc_plus4;
      default: result = in_alu_result;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values and the block order cannot create races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      wb_en        <= 1'b0;
      rd_index     <= 5'd0;
      wb_data      <= 32'd0;
      ecall_sig    <= 1'b0;
      retire_count <= 32'd0;
    end else begin
      case (state)
        RUN:     if (capture && in_ecall) state <= ECALL;
        ECALL:   state <= halt_in ? HALTED : RUN;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase

      if (capture) begin
        // An ECALL with reg_write set still writes back like any other op.
        wb_en     <= in_reg_write && (in_rd != 5'd0);
        rd_index  <= in_rd;
        wb_data   <= result;
        ecall_sig <= in_ecall;
        if (retire_count != 32'hFFFF_FFFF) retire_count <= retire_count + 32'd1;
      end else begin
        wb_en     <= 1'b0;
        rd_index  <= 5'd0;
        wb_data   <= 32'd0;
        ecall_sig <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage -- self-checking bench for wb_stage.
// A behavioural model tracks what the stage must present after each edge;
// one process compares DUT outputs with it on every falling edge. Directed
// transactions with hand-computed literals pin the model, then a randomized
// run (including asynchronous resets) exercises the rest.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_reg_write, in_ecall, halt_in;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4;
  logic        wb_en, ecall_sig, stall_req, halted;
  logic [4:0]  rd_index;
  logic [31:0] wb_data, retire_count;

  int total = 0;
  int bad   = 0;

  wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .in_ecall(in_ecall), .in_funct3(in_funct3), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4),
    .halt_in(halt_in), .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data),
    .ecall_sig(ecall_sig), .stall_req(stall_req), .halted(halted),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_RUN = 0, M_ECALL = 1, M_HALTED = 2;
  int          m_mode  = M_RUN;
  logic        m_wb_en = 1'b0, m_ecall = 1'b0;
  logic [4:0]  m_rd    = 5'd0;
  logic [31:0] m_data  = 32'd0, m_count = 32'd0;

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] addr,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> (8 * addr));
    h = 16'(rdata >> (16 * addr[1]));
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd4:    return 32'(b);
      3'd1:    return 32'($signed(h));
      3'd5:    return 32'(h);
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] result_value();
    if (in_wb_sel == 2'b10) return in_pc_plus4;
    if (in_wb_sel == 2'b01) return load_value(in_funct3, in_alu_result[1:0], in_mem_rdata);
    return in_alu_result;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_RUN; m_wb_en = 0; m_rd = 0; m_data = 0; m_ecall = 0; m_count = 0;
    end else begin
      bit taken;
      taken = in_valid && (m_mode == M_RUN);
      if (m_mode == M_ECALL)    m_mode = halt_in ? M_HALTED : M_RUN;
      else if (taken && in_ecall) m_mode = M_ECALL;
      if (taken) begin
        m_wb_en = in_reg_write && (in_rd != 0);
        m_rd    = in_rd;
        m_data  = result_value();
        m_ecall = in_ecall;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      end else begin
        m_wb_en = 0; m_rd = 0; m_data = 0; m_ecall = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_wb_en",     32'(wb_en),     32'(m_wb_en));
    check("cmp_rd_index",  32'(rd_index),  32'(m_rd));
    check("cmp_wb_data",   wb_data,        m_data);
    check("cmp_ecall_sig", 32'(ecall_sig), 32'(m_ecall));
    check("cmp_stall_req", 32'(stall_req), 32'(m_mode != M_RUN));
    check("cmp_halted",    32'(halted),    32'(m_mode == M_HALTED));
    check("cmp_count",     retire_count,   m_count);
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic v, input logic rw, input logic [4:0] rd, input logic ec,
                       input logic [2:0] f3, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc, input logic h);
    in_valid = v; in_reg_write = rw; in_rd = rd; in_ecall = ec; in_funct3 = f3;
    in_wb_sel = sel; in_alu_result = alu; in_mem_rdata = mem; in_pc_plus4 = pc; halt_in = h;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wb_en"},  32'(wb_en),     32'd0);
    check({tag, "_rd"},     32'(rd_index),  32'd0);
    check({tag, "_data"},   wb_data,        32'd0);
    check({tag, "_ecall"},  32'(ecall_sig), 32'd0);
    check({tag, "_stall"},  32'(stall_req), 32'd0);
    check({tag, "_halted"}, 32'(halted),    32'd0);
    check({tag, "_count"},  retire_count,   32'd0);
  endtask

  localparam logic [31:0] MEM = 32'h80FF_7F01;

  initial begin
    reset = 1'b1;
    in_valid = 0; in_reg_write = 0; in_rd = 0; in_ecall = 0; in_funct3 = 0;
    in_wb_sel = 0; in_alu_result = 0; in_mem_rdata = 0; in_pc_plus4 = 0; halt_in = 0;
    #1 reset = 1'b0;
    #1 check_zero("reset");
    #10 reset = 1'b1;                      // released at t=12, first capture at t=15

    // ALU write-back
    apply(1, 1, 5'd5, 0, 3'd0, 2'b00, 32'h1234, 0, 0, 0);
    check("alu_wb_en", 32'(wb_en), 1);
    check("alu_rd", 32'(rd_index), 5);
    check("alu_data", wb_data, 32'h0000_1234);
    check("alu_count", retire_count, 1);

    // Load alignment
    apply(1, 1, 5'd1, 0, 3'b000, 2'b01, 32'd3, MEM, 0, 0);
    check("lb_addr3", wb_data, 32'hFFFF_FF80);
    apply(1, 1, 5'd1, 0, 3'b100, 2'b01, 32'd2, MEM, 0, 0);
    check("lbu_addr2", wb_data, 32'h0000_00FF);
    apply(1, 1, 5'd1, 0, 3'b001, 2'b01, 32'd2, MEM, 0, 0);
    check("lh_addr2", wb_data, 32'hFFFF_80FF);
    apply(1, 1, 5'd1, 0, 3'b101, 2'b01, 32'd0, MEM, 0, 0);
    check("lhu_addr0", wb_data, 32'h0000_7F01);
    apply(1, 1, 5'd1, 0, 3'b010, 2'b01, 32'd1, MEM, 0, 0);
    check("lw", wb_data, MEM);
    check("load_count", retire_count, 6);

    // x0 suppression
    apply(1, 1, 5'd0, 0, 3'd0, 2'b10, 32'h99, 0, 32'h40, 0);
    check("x0_wb_en", 32'(wb_en), 0);
    check("x0_data", wb_data, 32'h40);
    check("x0_count", retire_count, 7);

    // ECALL resuming
    apply(1, 0, 5'd0, 1, 3'd0, 2'b00, 0, 0, 0, 0);
    check("ec0_sig", 32'(ecall_sig), 1);
    check("ec0_stall", 32'(stall_req), 1);
    check("ec0_count", retire_count, 8);
    apply(1, 1, 5'd7, 0, 3'd0, 2'b00, 32'hAB, 0, 0, 0);   // held during ECALL
    check("ec0_done_sig", 32'(ecall_sig), 0);
    check("ec0_done_stall", 32'(stall_req), 0);
    check("ec0_done_wb", 32'(wb_en), 0);
    check("ec0_done_count", retire_count, 8);
    apply(1, 1, 5'd7, 0, 3'd0, 2'b00, 32'hAB, 0, 0, 0);
    check("resume_wb", 32'(wb_en), 1);
    check("resume_data", wb_data, 32'hAB);
    check("resume_count", retire_count, 9);

    // ECALL halting (ecall with reg_write still writes back)
    apply(1, 1, 5'd3, 1, 3'd0, 2'b00, 32'h55, 0, 0, 0);
    check("ec1_sig", 32'(ecall_sig), 1);
    check("ec1_wb", 32'(wb_en), 1);
    apply(1, 1, 5'd4, 0, 3'd0, 2'b00, 32'h66, 0, 0, 1);
    check("halt_halted", 32'(halted), 1);
    check("halt_stall", 32'(stall_req), 1);
    repeat (3) apply(1, 1, 5'd4, 1, 3'd0, 2'b00, 32'h66, 0, 0, 0);
    check("halt_wb", 32'(wb_en), 0);
    check("halt_count", retire_count, 10);

    // Reset mid-HALTED, between edges
    #2 reset = 1'b0;
    #1 check_zero("rst_halted");
    #3 reset = 1'b1;
    apply(1, 1, 5'd9, 0, 3'd0, 2'b00, 32'h77, 0, 0, 0);
    check("post_rst_wb", 32'(wb_en), 1);
    check("post_rst_count", retire_count, 1);

    // Saturation: preload the counter just below its ceiling
    force dut.retire_count = 32'hFFFF_FFFE;
    #1 release dut.retire_count;
    m_count = 32'hFFFF_FFFE;
    apply(1, 1, 5'd9, 0, 3'd0, 2'b00, 32'h1, 0, 0, 0);
    check("sat_reach", retire_count, 32'hFFFF_FFFF);
    apply(1, 1, 5'd9, 0, 3'd0, 2'b00, 32'h2, 0, 0, 0);
    check("sat_hold", retire_count, 32'hFFFF_FFFF);
    #2 reset = 1'b0;
    #1 check_zero("rst_sat");
    #3 reset = 1'b1;

    // Randomized run with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
      apply($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), $urandom_range(0, 15) == 0,
            3'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(0, 7) == 0);
    end

    #10;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
